// File: rtl/licznik_sekwencer.sv
// Round-robin sequencer for the mod-12 up/down/halve counter. It grants one of two requesters,
// drives the counter's mode input for the requested number of cycles and keeps a shadow of its value.
module licznik_sekwencer #(
  parameter int MODULO = 12,
  parameter int BITY   = 4,
  parameter int CNT_W  = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_a,
  input  logic [1:0]       tryb_a,
  input  logic [CNT_W-1:0] ile_a,
  input  logic             req_b,
  input  logic [1:0]       tryb_b,
  input  logic [CNT_W-1:0] ile_b,
  output logic             ack_a,
  output logic             ack_b,
  output logic             done_a,
  output logic             done_b,
  output logic [1:0]       tryb_out,
  output logic             zajety,
  output logic [BITY-1:0]  cien,
  output logic             wyjscie_cien
);

  localparam logic [BITY-1:0]  CIEN_MAX  = BITY'(MODULO - 1);
  localparam logic [BITY-1:0]  CIEN_PROG = BITY'(5);
  localparam logic [CNT_W-1:0] REM_LAST  = CNT_W'(1);

  localparam logic [1:0] TRYB_STOP = 2'b00;
  localparam logic [1:0] TRYB_UP   = 2'b01;
  localparam logic [1:0] TRYB_DOWN = 2'b10;
  localparam logic [1:0] TRYB_HALF = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state, state_next;
  logic             owner_b, owner_b_next;
  logic             last_b, last_b_next;
  logic [1:0]       mode, mode_next;
  logic [CNT_W-1:0] rem, rem_next;

  logic             ack_a_next, ack_b_next;
  logic             done_a_next, done_b_next;
  logic [1:0]       tryb_next;
  logic             zajety_next;
  logic [BITY-1:0]  cien_next;
  logic             wyjscie_next;

  logic             any_req;
  logic             grant_b;
  logic [1:0]       tryb_sel;
  logic [CNT_W-1:0] ile_sel;

  // One step of the counter being mirrored; must match the real counter exactly.
  function automatic logic [BITY-1:0] krok(input logic [1:0] t, input logic [BITY-1:0] c);
    logic [BITY-1:0] n;
    case (t)
      TRYB_UP:   n = (c == CIEN_MAX) ? '0 : c + BITY'(1);
      TRYB_DOWN: n = (c == '0) ? CIEN_MAX : c - BITY'(1);
      TRYB_HALF: n = c >> 1;
      default:   n = c;
    endcase
    return n;
  endfunction

  // On a tie the requester that was not served last wins.
  always_comb begin
    any_req  = req_a | req_b;
    grant_b  = req_b & (~req_a | ~last_b);
    tryb_sel = grant_b ? tryb_b : tryb_a;
    ile_sel  = grant_b ? ile_b : ile_a;
  end

  // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_next   = state;
    owner_b_next = owner_b;
    last_b_next  = last_b;
    mode_next    = mode;
    rem_next     = rem;
    ack_a_next   = 1'b0;
    ack_b_next   = 1'b0;
    done_a_next  = 1'b0;
    done_b_next  = 1'b0;
    tryb_next    = TRYB_STOP;

    unique case (state)
      IDLE: begin
        if (any_req) begin
          owner_b_next = grant_b;
          mode_next    = tryb_sel;
          ack_a_next   = ~grant_b;
          ack_b_next   = grant_b;
          if (ile_sel != '0) begin
            state_next = RUN;
            rem_next   = ile_sel;
            tryb_next  = tryb_sel;
          end else begin
            // A zero-length run reports completion together with the acknowledge.
            state_next  = DONE;
            rem_next    = '0;
            done_a_next = ~grant_b;
            done_b_next = grant_b;
          end
        end
      end

      RUN: begin
        rem_next = rem - REM_LAST;
        if (rem == REM_LAST) begin
          state_next  = DONE;
          done_a_next = ~owner_b;
          done_b_next = owner_b;
        end else begin
          tryb_next = mode;
        end
      end

      DONE: begin
        last_b_next = owner_b;
        state_next  = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase

    zajety_next = (state_next != IDLE);
  end

  // The shadow follows the mode currently presented to the counter, so it moves in lockstep with it.
  always_comb begin
    cien_next    = krok(tryb_out, cien);
    wyjscie_next = (cien_next >= CIEN_PROG);
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      owner_b      <= 1'b0;
      last_b       <= 1'b1;
      mode         <= TRYB_STOP;
      rem          <= '0;
      ack_a        <= 1'b0;
      ack_b        <= 1'b0;
      done_a       <= 1'b0;
      done_b       <= 1'b0;
      tryb_out     <= TRYB_STOP;
      zajety       <= 1'b0;
      cien         <= '0;
      wyjscie_cien <= 1'b0;
    end else begin
      state        <= state_next;
      owner_b      <= owner_b_next;
      last_b       <= last_b_next;
      mode         <= mode_next;
      rem          <= rem_next;
      ack_a        <= ack_a_next;
      ack_b        <= ack_b_next;
      done_a       <= done_a_next;
      done_b       <= done_b_next;
      tryb_out     <= tryb_next;
      zajety       <= zajety_next;
      cien         <= cien_next;
      wyjscie_cien <= wyjscie_next;
    end
  end

  a_ack_onehot: assert property (@(posedge clk) disable iff (reset) !(ack_a && ack_b));
  a_done_onehot: assert property (@(posedge clk) disable iff (reset) !(done_a && done_b));
  a_cien_range: assert property (@(posedge clk) disable iff (reset) cien <= CIEN_MAX);

endmodule
